// File: rtl/defines_pkg.sv
// Shared types for the SPU dual-issue scheduler.
//   opcode_t        decoded opcodes, including the even-pipe NOP and odd-pipe LNOP
//   pipe_t          execution pipe select (PIPE_EVEN = 0, PIPE_ODD = 1)
//   reg_addr_t      architectural register address
//   issue_bundle_t  everything an issue port carries for one instruction
//   idle_bundle()   the filler bundle a pipe receives when nothing issues to it
package defines_pkg;

  localparam int REG_AW  = 7;
  localparam int INSTR_W = 32;

  typedef enum logic [7:0] {
    NOP   = 8'h00,
    LNOP  = 8'h01,
    ADD   = 8'h10,
    FA    = 8'h11,
    MPY   = 8'h12,
    SHUFB = 8'h20,
    LQD   = 8'h21,
    STQD  = 8'h22,
    BR    = 8'h23
  } opcode_t;

  typedef enum logic {
    PIPE_EVEN = 1'b0,
    PIPE_ODD  = 1'b1
  } pipe_t;

  typedef logic [0:REG_AW-1] reg_addr_t;

  typedef struct packed {
    opcode_t              opcode;
    logic [0:INSTR_W-1]   instr;
    reg_addr_t            ra;
    reg_addr_t            rb;
    reg_addr_t            rc;
    reg_addr_t            rt;
  } issue_bundle_t;

  // NOP on the even pipe, LNOP on the odd pipe, every other field zero.
  function automatic issue_bundle_t idle_bundle(input pipe_t pipe);
    issue_bundle_t b;
    b        = '0;
    b.opcode = (pipe == PIPE_ODD) ? LNOP : NOP;
    return b;
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Per-register latency scoreboard.
// Each entry holds the number of further cycles a dependent instruction
// must wait; a register is busy while its entry is nonzero.
//   clk, rst        clock, asynchronous active-high reset
//   flush           clears every entry at the next edge
//   wr_en/addr/lat  two load ports (slot 0, slot 1) for accepted writers
//   src_addr/busy   six source lookups (ra/rb/rc of slot 0, then of slot 1)
//   rt_addr/busy    two destination lookups (slot 0, slot 1)
module issue_scoreboard
  import defines_pkg::*;
#(
  parameter int NUM_REGS = 128,
  parameter int LAT_WD   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [0:1]             wr_en,
  input  reg_addr_t [0:1]        wr_addr,
  input  logic [0:1][0:LAT_WD-1] wr_lat,
  input  reg_addr_t [0:5]        src_addr,
  output logic [0:5]             src_busy,
  input  reg_addr_t [0:1]        rt_addr,
  output logic [0:1]             rt_busy
);

  logic [LAT_WD-1:0] cnt [NUM_REGS];
  logic [LAT_WD-1:0] load_val [2];

  // A producer accepted in cycle T with latency L lets its consumer issue in
  // cycle T+L. The entry is first visible in cycle T+1, so it is loaded with
  // L-1: the consumer then sees L-1 busy cycles. Latency 0 is treated as 1.
  always_comb begin
    for (int w = 0; w < 2; w++) begin
      load_val[w] = (wr_lat[w] == '0) ? '0 : wr_lat[w] - LAT_WD'(1);
    end
  end

  // NOTE: the counters are architectural state whose stale contents would
  // create false hazards after reset, so unlike a data RAM every entry is
  // cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        // Both writers never target the same rt (pairing forbids it), so
        // the priority between them is arbitrary; a load beats the decrement.
        if (wr_en[1] && wr_addr[1] == REG_AW'(i)) begin
          cnt[i] <= load_val[1];
        end else if (wr_en[0] && wr_addr[0] == REG_AW'(i)) begin
          cnt[i] <= load_val[0];
        end else if (cnt[i] != '0) begin
          cnt[i] <= cnt[i] - LAT_WD'(1);
        end
      end
    end
  end

  always_comb begin
    for (int s = 0; s < 6; s++) src_busy[s] = (cnt[src_addr[s]] != '0);
    for (int t = 0; t < 2; t++) rt_busy[t]  = (cnt[rt_addr[t]] != '0);
  end

endmodule

// File: rtl/issue_ctrl.sv
// Dual-issue scheduler between decode and the SPU even/odd pipes.
// Accepts zero, one or two decoded instructions per cycle in program order,
// subject to scoreboard (RAW/WAW) hazards and intra-pair conflicts, and
// registers them onto the even and odd issue ports.
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid                 per-slot valid, slot 0 is older
//   in_opcode/in_instr       decoded opcode and raw word per slot
//   in_pipe                  per-slot target pipe (0 even, 1 odd)
//   in_ra/rb/rc/rt_addr      per-slot register addresses
//   in_src_used              per-slot ra/rb/rc read flags
//   in_wr_rt, in_lat         per-slot rt write flag and result latency
//   flush                    branch-mispredict flush
//   accept                   slots consumed this cycle (combinational)
//   *_ep / *_op              registered even / odd issue ports
//   stall_cnt                saturating count of stalled slot-0 cycles
module issue_ctrl
  import defines_pkg::*;
#(
  parameter int NUM_REGS = 128,
  parameter int LAT_WD   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [0:1]             in_valid,
  input  opcode_t [0:1]          in_opcode,
  input  logic [0:1][0:31]       in_instr,
  input  logic [0:1]             in_pipe,
  input  logic [0:1][0:6]        in_ra_addr,
  input  logic [0:1][0:6]        in_rb_addr,
  input  logic [0:1][0:6]        in_rc_addr,
  input  logic [0:1][0:6]        in_rt_addr,
  input  logic [0:1][0:2]        in_src_used,
  input  logic [0:1]             in_wr_rt,
  input  logic [0:1][0:LAT_WD-1] in_lat,
  input  logic                   flush,
  output logic [0:1]             accept,
  output opcode_t                opcode_ep,
  output opcode_t                opcode_op,
  output logic [0:31]            instr_ep,
  output logic [0:31]            instr_op,
  output logic [0:6]             ra_addr_ep,
  output logic [0:6]             rb_addr_ep,
  output logic [0:6]             rc_addr_ep,
  output logic [0:6]             rt_addr_ep,
  output logic [0:6]             ra_addr_op,
  output logic [0:6]             rb_addr_op,
  output logic [0:6]             rc_addr_op,
  output logic [0:6]             rt_addr_op,
  output logic [0:31]            stall_cnt
);

  logic [0:5]    src_busy;
  logic [0:1]    rt_busy;
  logic [0:1]    sb_wr_en;
  logic [0:1]    hazard;
  logic          raw_pair;
  logic          waw_pair;
  logic          acc0;
  logic          acc1;
  issue_bundle_t slot [2];
  issue_bundle_t nxt_ep;
  issue_bundle_t nxt_op;
  issue_bundle_t iss_ep;
  issue_bundle_t iss_op;

  issue_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .LAT_WD   (LAT_WD)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .wr_en    (sb_wr_en),
    .wr_addr  (in_rt_addr),
    .wr_lat   (in_lat),
    .src_addr ({in_ra_addr[0], in_rb_addr[0], in_rc_addr[0],
                in_ra_addr[1], in_rb_addr[1], in_rc_addr[1]}),
    .src_busy (src_busy),
    .rt_addr  (in_rt_addr),
    .rt_busy  (rt_busy)
  );

  // Scoreboard hazard per slot: a used source or the written rt is busy.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      hazard[s] = (in_src_used[s][0] & src_busy[3*s])
                | (in_src_used[s][1] & src_busy[3*s+1])
                | (in_src_used[s][2] & src_busy[3*s+2])
                | (in_wr_rt[s] & rt_busy[s]);
    end
  end

  // Intra-pair conflicts: slot 1 reading or rewriting slot 0's destination.
  assign raw_pair = in_wr_rt[0] &
                    ((in_src_used[1][0] & (in_ra_addr[1] == in_rt_addr[0])) |
                     (in_src_used[1][1] & (in_rb_addr[1] == in_rt_addr[0])) |
                     (in_src_used[1][2] & (in_rc_addr[1] == in_rt_addr[0])));
  assign waw_pair = in_wr_rt[0] & in_wr_rt[1] & (in_rt_addr[1] == in_rt_addr[0]);

  // Slot 1 can only go with slot 0, so in_valid = 01 is never accepted.
  assign acc0 = in_valid[0] & ~hazard[0] & ~flush;
  assign acc1 = acc0 & in_valid[1] & (in_pipe[1] != in_pipe[0]) &
                ~hazard[1] & ~raw_pair & ~waw_pair;

  assign accept   = 2'(acc0) + 2'(acc1);
  assign sb_wr_en = {acc0 & in_wr_rt[0], acc1 & in_wr_rt[1]};

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      slot[s].opcode = in_opcode[s];
      slot[s].instr  = in_instr[s];
      slot[s].ra     = in_ra_addr[s];
      slot[s].rb     = in_rb_addr[s];
      slot[s].rc     = in_rc_addr[s];
      slot[s].rt     = in_rt_addr[s];
    end
  end

  // NOTE: every always_comb output gets a default before any condition, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    nxt_ep = idle_bundle(PIPE_EVEN);
    nxt_op = idle_bundle(PIPE_ODD);
    if (acc0) begin
      if (in_pipe[0] == PIPE_ODD) nxt_op = slot[0];
      else                        nxt_ep = slot[0];
    end
    // acc1 implies the pipes differ, so this never overwrites slot 0.
    if (acc1) begin
      if (in_pipe[1] == PIPE_ODD) nxt_op = slot[1];
      else                        nxt_ep = slot[1];
    end
  end

  // NOTE: registered state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_ep <= idle_bundle(PIPE_EVEN);
      iss_op <= idle_bundle(PIPE_ODD);
    end else begin
      iss_ep <= nxt_ep;
      iss_op <= nxt_op;
    end
  end

  // accept = 0 with a valid slot 0 is exactly !acc0; flush cycles are not stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (in_valid[0] && !acc0 && !flush && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign opcode_ep  = iss_ep.opcode;
  assign instr_ep   = iss_ep.instr;
  assign ra_addr_ep = iss_ep.ra;
  assign rb_addr_ep = iss_ep.rb;
  assign rc_addr_ep = iss_ep.rc;
  assign rt_addr_ep = iss_ep.rt;
  assign opcode_op  = iss_op.opcode;
  assign instr_op   = iss_op.instr;
  assign ra_addr_op = iss_op.ra;
  assign rb_addr_op = iss_op.rb;
  assign rc_addr_op = iss_op.rc;
  assign rt_addr_op = iss_op.rt;

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl. The reference model tracks, per
// register, the cycle number from which it may be read; a driver predicts
// accept and the issue-port contents and queues them, a monitor compares.
module tb_issue_ctrl;
  import defines_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [0:1]       in_valid = '0;
  opcode_t [0:1]    in_opcode = {NOP, NOP};
  logic [0:1][0:31] in_instr = '0;
  logic [0:1]       in_pipe = '0;
  logic [0:1][0:6]  in_ra_addr = '0, in_rb_addr = '0, in_rc_addr = '0, in_rt_addr = '0;
  logic [0:1][0:2]  in_src_used = '0;
  logic [0:1]       in_wr_rt = '0;
  logic [0:1][0:2]  in_lat = '0;
  logic             flush = 1'b0;
  logic [0:1]       accept;
  opcode_t          opcode_ep, opcode_op;
  logic [0:31]      instr_ep, instr_op;
  logic [0:6]       ra_addr_ep, rb_addr_ep, rc_addr_ep, rt_addr_ep;
  logic [0:6]       ra_addr_op, rb_addr_op, rc_addr_op, rt_addr_op;
  logic [0:31]      stall_cnt;

  issue_ctrl #(.NUM_REGS(128), .LAT_WD(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_opcode(in_opcode),
    .in_instr(in_instr), .in_pipe(in_pipe), .in_ra_addr(in_ra_addr),
    .in_rb_addr(in_rb_addr), .in_rc_addr(in_rc_addr), .in_rt_addr(in_rt_addr),
    .in_src_used(in_src_used), .in_wr_rt(in_wr_rt), .in_lat(in_lat),
    .flush(flush), .accept(accept), .opcode_ep(opcode_ep), .opcode_op(opcode_op),
    .instr_ep(instr_ep), .instr_op(instr_op), .ra_addr_ep(ra_addr_ep),
    .rb_addr_ep(rb_addr_ep), .rc_addr_ep(rc_addr_ep), .rt_addr_ep(rt_addr_ep),
    .ra_addr_op(ra_addr_op), .rb_addr_op(rb_addr_op), .rc_addr_op(rc_addr_op),
    .rt_addr_op(rt_addr_op), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    opcode_t     op;
    logic [31:0] instr;
    logic        pipe;
    int          ra, rb, rc, rt;
    logic [0:2]  used;
    logic        wr;
    int          lat;
  } slot_t;

  typedef struct {
    issue_bundle_t ep;
    issue_bundle_t op;
    logic [31:0]   stall;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          ready_at [128];
  int          cyc = 0;
  logic [31:0] m_stall = 0;
  int          last_acc;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic slot_t mk(input logic v, input opcode_t op, input logic pipe,
                               input int ra, input int rb, input int rc, input int rt,
                               input logic [0:2] used, input logic wr, input int lat);
    slot_t s;
    s.v = v; s.op = op; s.instr = $urandom; s.pipe = pipe;
    s.ra = ra; s.rb = rb; s.rc = rc; s.rt = rt;
    s.used = used; s.wr = wr; s.lat = lat;
    return s;
  endfunction

  function automatic bit busy(input int r);
    return ready_at[r] > cyc;
  endfunction

  function automatic bit blocked(input slot_t s);
    return (s.used[0] && busy(s.ra)) || (s.used[1] && busy(s.rb)) ||
           (s.used[2] && busy(s.rc)) || (s.wr && busy(s.rt));
  endfunction

  function automatic bit reads(input slot_t s, input int r);
    return (s.used[0] && s.ra == r) || (s.used[1] && s.rb == r) || (s.used[2] && s.rc == r);
  endfunction

  function automatic issue_bundle_t to_bundle(input slot_t s);
    issue_bundle_t b;
    b.opcode = s.op; b.instr = s.instr;
    b.ra = 7'(s.ra); b.rb = 7'(s.rb); b.rc = 7'(s.rc); b.rt = 7'(s.rt);
    return b;
  endfunction

  function automatic issue_bundle_t nop_b(input logic odd);
    issue_bundle_t b;
    b = '0;
    b.opcode = odd ? LNOP : NOP;
    return b;
  endfunction

  task automatic model_reset();
    foreach (ready_at[i]) ready_at[i] = 0;
    m_stall = 0;
  endtask

  // One cycle: apply inputs at the falling edge, predict and check accept,
  // queue the expected post-edge issue ports, advance the model.
  task automatic drive(input slot_t s0, input slot_t s1, input logic fl);
    bit   a0, a1;
    exp_t e;
    @(negedge clk);
    in_valid    = {s0.v, s1.v};
    in_opcode   = {s0.op, s1.op};
    in_instr    = {s0.instr, s1.instr};
    in_pipe     = {s0.pipe, s1.pipe};
    in_ra_addr  = {7'(s0.ra), 7'(s1.ra)};
    in_rb_addr  = {7'(s0.rb), 7'(s1.rb)};
    in_rc_addr  = {7'(s0.rc), 7'(s1.rc)};
    in_rt_addr  = {7'(s0.rt), 7'(s1.rt)};
    in_src_used = {s0.used, s1.used};
    in_wr_rt    = {s0.wr, s1.wr};
    in_lat      = {3'(s0.lat), 3'(s1.lat)};
    flush       = fl;
    #1;
    a0 = s0.v && !blocked(s0) && !fl;
    a1 = a0 && s1.v && (s1.pipe != s0.pipe) && !blocked(s1) &&
         !(s0.wr && reads(s1, s0.rt)) && !(s0.wr && s1.wr && s1.rt == s0.rt);
    check("accept", 128'(accept), 128'(int'(a0) + int'(a1)));
    last_acc = int'(accept);
    e.ep = nop_b(1'b0);
    e.op = nop_b(1'b1);
    if (a0) begin
      if (s0.pipe) e.op = to_bundle(s0); else e.ep = to_bundle(s0);
      if (s0.wr) ready_at[s0.rt] = cyc + s0.lat;
    end
    if (a1) begin
      if (s1.pipe) e.op = to_bundle(s1); else e.ep = to_bundle(s1);
      if (s1.wr) ready_at[s1.rt] = cyc + s1.lat;
    end
    if (fl) foreach (ready_at[i]) ready_at[i] = 0;
    if (s0.v && !a0 && !fl && m_stall != 32'hFFFF_FFFF) m_stall++;
    e.stall = m_stall;
    q.push_back(e);
    cyc++;
  endtask

  task automatic idle_inputs();
    in_valid = '0; in_src_used = '0; in_wr_rt = '0; flush = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    idle_inputs();
    #1;
    check("rst_ep", 128'(issue_bundle_t'({opcode_ep, instr_ep, ra_addr_ep, rb_addr_ep, rc_addr_ep, rt_addr_ep})),
          128'(nop_b(1'b0)));
    check("rst_op", 128'(issue_bundle_t'({opcode_op, instr_op, ra_addr_op, rb_addr_op, rc_addr_op, rt_addr_op})),
          128'(nop_b(1'b1)));
    check("rst_stall", 128'(stall_cnt), 128'(0));
    q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: one queued expectation per clock edge following a driven cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && q.size() > 0) begin
        e = q.pop_front();
        check("issue_ep", 128'(issue_bundle_t'({opcode_ep, instr_ep, ra_addr_ep, rb_addr_ep, rc_addr_ep, rt_addr_ep})),
              128'(e.ep));
        check("issue_op", 128'(issue_bundle_t'({opcode_op, instr_op, ra_addr_op, rb_addr_op, rc_addr_op, rt_addr_op})),
              128'(e.op));
        check("stall_cnt", 128'(stall_cnt), 128'(e.stall));
      end
    end
  end

  function automatic slot_t rand_slot(input logic v);
    opcode_t ops [6] = '{ADD, FA, MPY, SHUFB, LQD, BR};
    return mk(v, ops[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
              $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 15), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              $urandom_range(1, 7));
  endfunction

  initial begin
    slot_t none, s0, s1;
    int    exp_acc [4] = '{0, 0, 0, 1};
    int    guard;
    none = mk(1'b0, NOP, 1'b0, 0, 0, 0, 0, 3'b000, 1'b0, 1);
    model_reset();
    do_reset();

    // Independent pair: add rt=3 even, shuffle rt=4 odd.
    drive(mk(1, ADD, 0, 1, 2, 0, 3, 3'b110, 1, 2), mk(1, SHUFB, 1, 5, 6, 0, 4, 3'b110, 1, 3), 0);
    check("pair_accept", 128'(last_acc), 128'(2));

    // Two even instructions: only slot 0, then slot 1 re-presented.
    s1 = mk(1, FA, 0, 20, 21, 0, 23, 3'b110, 1, 2);
    drive(mk(1, ADD, 0, 10, 11, 0, 12, 3'b110, 1, 2), s1, 0);
    check("same_pipe_accept", 128'(last_acc), 128'(1));
    drive(s1, none, 0);
    check("same_pipe_reissue", 128'(last_acc), 128'(1));

    // RAW through the scoreboard: r5 with latency 4 stalls its reader 3 cycles.
    do_reset();
    drive(mk(1, MPY, 0, 1, 2, 0, 5, 3'b110, 1, 4), none, 0);
    s0 = mk(1, ADD, 0, 5, 0, 0, 6, 3'b100, 1, 1);
    for (int i = 0; i < 4; i++) begin
      drive(s0, none, 0);
      check("raw_stall_accept", 128'(last_acc), 128'(exp_acc[i]));
    end
    @(posedge clk);
    #2;
    check("raw_stall_cnt", 128'(stall_cnt), 128'(3));

    // In-pair RAW on r7: slot 1 waits, then issues alone.
    s1 = mk(1, SHUFB, 1, 7, 0, 0, 8, 3'b100, 1, 1);
    drive(mk(1, ADD, 0, 1, 2, 0, 7, 3'b110, 1, 1), s1, 0);
    check("pair_raw_accept", 128'(last_acc), 128'(1));
    drive(s1, none, 0);
    check("pair_raw_reissue", 128'(last_acc), 128'(1));

    // Flush while r9 is busy, then its reader goes straight through.
    do_reset();
    drive(mk(1, MPY, 0, 1, 2, 0, 9, 3'b110, 1, 6), none, 0);
    s0 = mk(1, ADD, 0, 9, 0, 0, 10, 3'b100, 1, 1);
    drive(s0, none, 1);
    check("flush_accept", 128'(last_acc), 128'(0));
    drive(s0, none, 0);
    check("post_flush_accept", 128'(last_acc), 128'(1));

    // Build stall_cnt = 10 with r1, r2, r3 busy, then reset mid-operation.
    do_reset();
    s0 = mk(1, MPY, 0, 1, 0, 0, 1, 3'b100, 1, 7);
    guard = 0;
    while (m_stall < 10 && guard < 60) begin
      drive(s0, none, 0);
      guard++;
    end
    check("stall_build_bound", 128'(guard < 60), 128'(1));
    drive(mk(1, FA, 0, 0, 0, 0, 2, 3'b000, 1, 7), mk(1, LQD, 1, 0, 0, 0, 3, 3'b000, 1, 7), 0);
    @(posedge clk);
    #2;
    check("stall_ten", 128'(stall_cnt), 128'(10));
    do_reset();
    drive(mk(1, ADD, 0, 1, 2, 0, 4, 3'b110, 1, 2), mk(1, SHUFB, 1, 3, 0, 0, 5, 3'b100, 1, 2), 0);
    check("post_reset_pair", 128'(last_acc), 128'(2));

    // Randomized traffic, including illegal 01 patterns and flushes.
    for (int n = 0; n < 400; n++) begin
      logic v0, v1;
      v0 = ($urandom_range(0, 7) != 0);
      v1 = ($urandom_range(0, 3) != 0);
      if (n == 200) do_reset();
      drive(rand_slot(v0), rand_slot(v1), ($urandom_range(0, 15) == 0));
    end

    @(negedge clk);
    idle_inputs();
    repeat (2) @(posedge clk);
    #2;
    check("queue_drained", 128'(q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
